// File: rtl/dp_sram_pkg.sv
// dp_sram_pkg: clear-FSM state type, write-priority constant and byte-merge helper
package dp_sram_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam bit PRIO_A = 1'b1;
  // byte_merge works on a fixed maximum width; callers zero-extend and truncate.
  localparam int MAX_DW = 1024;
  localparam int MAX_BE = MAX_DW / 8;
  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old, input logic [MAX_DW-1:0] din, input logic [MAX_BE-1:0] be);
    logic [MAX_DW-1:0] w;
    for (int i = 0; i < MAX_BE; i++) w[8*i+:8] = be[i] ? din[8*i+:8] : old[8*i+:8];
    return w;
  endfunction
endpackage

// File: rtl/dp_sram_be_if.sv
// dp_sram_be_if: one SRAM client port (en, wr, be, addr, din -> dout, vld[, perr])
// master = client side, slave = memory side; perr exists only with DP_SRAM_PARITY_EN.
interface dp_sram_be_if #(parameter int DATA_W = 32, parameter int ADDR_W = 3);
  localparam int BE_W = DATA_W / 8;
  logic en, wr, vld;
  logic [BE_W-1:0] be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din, dout;
`ifdef DP_SRAM_PARITY_EN
  logic perr;
  modport master(output en, wr, be, addr, din, input dout, vld, perr);
  modport slave(input en, wr, be, addr, din, output dout, vld, perr);
`else
  modport master(output en, wr, be, addr, din, input dout, vld);
  modport slave(input en, wr, be, addr, din, output dout, vld);
`endif
endinterface

// File: rtl/dp_sram_port.sv
// dp_sram_port: per-port read register with one-cycle valid strobe (and parity error)
// clk, rst_n: clock / async active-low reset; rd_i: accepted read this cycle;
// data_i/par_i: addressed word before the edge; dout_o, vld_o, perr_o: registered results.
module dp_sram_port #(parameter int DATA_W = 32) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_i,
  input  logic [DATA_W-1:0] data_i,
`ifdef DP_SRAM_PARITY_EN
  input  logic [DATA_W/8-1:0] par_i,
  output logic              perr_o,
`endif
  output logic [DATA_W-1:0] dout_o,
  output logic              vld_o
);
  logic [DATA_W-1:0] dout_q, dout_d;
  logic vld_q;
  always_comb dout_d = rd_i ? data_i : dout_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= rd_i;
    end
  assign dout_o = dout_q;
  assign vld_o  = vld_q;
`ifdef DP_SRAM_PARITY_EN
  logic perr_q, perr_d;
  // Stored bit is even parity of its byte, so XOR of byte and bit must be 0.
  always_comb begin
    perr_d = 1'b0;
    for (int i = 0; i < DATA_W / 8; i++) perr_d |= par_i[i] ^ (^data_i[8*i+:8]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) perr_q <= 1'b0;
    else perr_q <= rd_i & perr_d;
  assign perr_o = perr_q;
`endif
endmodule

// File: rtl/dp_sram_be.sv
// dp_sram_be: true dual-port byte-enable SRAM with post-reset self-clear
// clk, rst_n: shared clock / async active-low reset; a_io, b_io: client ports (slave);
// init_done_o: clear finished; collision_o: overlapping same-address write bytes last cycle.
// Optional DP_SRAM_PARITY_EN stores an even-parity bit per byte and drives perr on each port.
module dp_sram_be import dp_sram_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         init_done_o,
  output logic         collision_o,
  dp_sram_be_if.slave  a_io,
  dp_sram_be_if.slave  b_io
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int BE_W = DATA_W / 8;
`ifdef DP_SRAM_PARITY_EN
  localparam int MEM_W = DATA_W + BE_W;
`else
  localparam int MEM_W = DATA_W;
`endif
  // Word layout is {parity bits, data}; the data merge and parity update share one helper.
  function automatic logic [MEM_W-1:0] wmerge(input logic [MEM_W-1:0] old, input logic [DATA_W-1:0] din, input logic [BE_W-1:0] be);
    logic [MEM_W-1:0] w;
    w[DATA_W-1:0] = DATA_W'(byte_merge(MAX_DW'(old[DATA_W-1:0]), MAX_DW'(din), MAX_BE'(be)));
`ifdef DP_SRAM_PARITY_EN
    for (int i = 0; i < BE_W; i++) w[DATA_W+i] = be[i] ? ^din[8*i+:8] : old[DATA_W+i];
`endif
    return w;
  endfunction
  logic [MEM_W-1:0] mem [DEPTH];
  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic col_q, col_d, ready, a_we, b_we, a_rd, b_rd, same_ww;
  logic [MEM_W-1:0] a_m, b_m, both_m;
  always_comb begin
    ready   = state_q == READY;
    a_we    = ready & a_io.en & a_io.wr;
    b_we    = ready & b_io.en & b_io.wr;
    a_rd    = ready & a_io.en & ~a_io.wr;
    b_rd    = ready & b_io.en & ~b_io.wr;
    same_ww = a_we & b_we & (a_io.addr == b_io.addr);
    a_m     = wmerge(mem[a_io.addr], a_io.din, a_io.be);
    b_m     = wmerge(mem[b_io.addr], b_io.din, b_io.be);
    // Same-address write pair: lower-priority port merges first, winner lays its bytes on top.
    both_m  = PRIO_A ? wmerge(b_m, a_io.din, a_io.be) : wmerge(a_m, b_io.din, b_io.be);
    state_d = (!ready && &clr_q) ? READY : state_q;
    clr_d   = ready ? clr_q : clr_q + 1'b1;
    col_d   = same_ww & |(a_io.be & b_io.be);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= CLEAR;
      clr_q   <= '0;
      col_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      col_q   <= col_d;
    end
  // Both ports store the same merged word on a same-address pair, so write order is irrelevant.
  always_ff @(posedge clk)
    if (!ready) mem[clr_q] <= '0;
    else begin
      if (b_we) mem[b_io.addr] <= same_ww ? both_m : b_m;
      if (a_we) mem[a_io.addr] <= same_ww ? both_m : a_m;
    end
  dp_sram_port #(.DATA_W(DATA_W)) u_port_a (
    .clk(clk), .rst_n(rst_n), .rd_i(a_rd), .data_i(mem[a_io.addr][DATA_W-1:0]),
`ifdef DP_SRAM_PARITY_EN
    .par_i(mem[a_io.addr][MEM_W-1:DATA_W]), .perr_o(a_io.perr),
`endif
    .dout_o(a_io.dout), .vld_o(a_io.vld)
  );
  dp_sram_port #(.DATA_W(DATA_W)) u_port_b (
    .clk(clk), .rst_n(rst_n), .rd_i(b_rd), .data_i(mem[b_io.addr][DATA_W-1:0]),
`ifdef DP_SRAM_PARITY_EN
    .par_i(mem[b_io.addr][MEM_W-1:DATA_W]), .perr_o(b_io.perr),
`endif
    .dout_o(b_io.dout), .vld_o(b_io.vld)
  );
  assign init_done_o = ready;
  assign collision_o = col_q;
endmodule

// File: tb/tb_dp_sram_be.sv
// tb_dp_sram_be: directed table, reset/clear sequences and random traffic against a word-array model
module tb_dp_sram_be;
  typedef struct packed {
    logic en, wr;
    logic [3:0] be;
    logic [2:0] addr;
    logic [31:0] din;
  } req_t;
  typedef struct {
    req_t a, b;
    logic avld;
    logic [31:0] adout;
    logic bvld;
    logic [31:0] bdout;
    logic col;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic init_done, collision;
  int checks = 0, failures = 0;
  logic [31:0] model [8];
  logic exp_avld, exp_bvld, exp_col;
  logic [31:0] exp_adout, exp_bdout;
  localparam req_t IDLE = '0;
  dp_sram_be_if #(.DATA_W(32), .ADDR_W(3)) a_if ();
  dp_sram_be_if #(.DATA_W(32), .ADDR_W(3)) b_if ();
  dp_sram_be #(.DATA_W(32), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .init_done_o(init_done), .collision_o(collision),
    .a_io(a_if), .b_io(b_if)
  );
  always #5 clk = ~clk;
  function automatic req_t wrq(input logic [3:0] be, input logic [2:0] addr, input logic [31:0] din);
    return '{en: 1'b1, wr: 1'b1, be: be, addr: addr, din: din};
  endfunction
  function automatic req_t rdq(input logic [2:0] addr);
    return '{en: 1'b1, wr: 1'b0, be: 4'h0, addr: addr, din: 32'h0};
  endfunction
  function automatic req_t rnd();
    req_t r;
    r.en = $urandom_range(0, 3) != 0;
    r.wr = 1'($urandom_range(0, 1));
    r.be = 4'($urandom);
    r.addr = $urandom_range(0, 1) != 0 ? 3'($urandom_range(0, 1)) : 3'($urandom);
    r.din = $urandom;
    return r;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input req_t a, input req_t b);
    a_if.en = a.en; a_if.wr = a.wr; a_if.be = a.be; a_if.addr = a.addr; a_if.din = a.din;
    b_if.en = b.en; b_if.wr = b.wr; b_if.be = b.be; b_if.addr = b.addr; b_if.din = b.din;
  endtask
  // One clock with the given requests; the model reads before it writes (read-first),
  // applies B's bytes then A's so A owns any byte both ports write.
  task automatic step(input req_t a, input req_t b, input bit chk);
    drive(a, b);
    exp_avld = a.en && !a.wr;
    exp_bvld = b.en && !b.wr;
    if (exp_avld) exp_adout = model[a.addr];
    if (exp_bvld) exp_bdout = model[b.addr];
    exp_col = a.en && a.wr && b.en && b.wr && a.addr == b.addr && (a.be & b.be) != 0;
    @(posedge clk); #1;
    if (b.en && b.wr) for (int i = 0; i < 4; i++) if (b.be[i]) model[b.addr][8*i+:8] = b.din[8*i+:8];
    if (a.en && a.wr) for (int i = 0; i < 4; i++) if (a.be[i]) model[a.addr][8*i+:8] = a.din[8*i+:8];
    if (chk) begin
      check("a_vld", 32'(a_if.vld), 32'(exp_avld));
      check("b_vld", 32'(b_if.vld), 32'(exp_bvld));
      check("a_dout", a_if.dout, exp_adout);
      check("b_dout", b_if.dout, exp_bdout);
      check("collision", 32'(collision), 32'(exp_col));
    end
  endtask
  // Assert reset, check the cleared outputs, release and time the self-clear.
  task automatic reset_init(input bit reqs);
    int n;
    rst_n = 1'b0; #1;
    check("rst_init_done", 32'(init_done), 32'h0);
    check("rst_a_vld", 32'(a_if.vld), 32'h0);
    check("rst_b_vld", 32'(b_if.vld), 32'h0);
    check("rst_a_dout", a_if.dout, 32'h0);
    check("rst_b_dout", b_if.dout, 32'h0);
    check("rst_collision", 32'(collision), 32'h0);
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    exp_adout = 32'h0;
    exp_bdout = 32'h0;
    repeat (2) @(posedge clk); #1;
    check("rst_hold_a_dout", a_if.dout, 32'h0);
    if (reqs) drive(wrq(4'hF, 3'd0, 32'h12345678), rdq(3'd0));
    else drive(IDLE, IDLE);
    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 40) begin
      @(posedge clk); #1;
      n++;
      check("clear_a_vld", 32'(a_if.vld), 32'h0);
      check("clear_b_vld", 32'(b_if.vld), 32'h0);
    end
    check("init_cycles", 32'(n), 32'd8);
    drive(IDLE, IDLE);
  endtask
  vec_t v [14];
  initial begin
    v[0]  = '{rdq(0), IDLE, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0};
    v[1]  = '{wrq(4'hF, 2, 32'h11223344), IDLE, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    v[2]  = '{wrq(4'h5, 2, 32'hAABBCCDD), IDLE, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
    v[3]  = '{IDLE, rdq(2), 1'b0, 32'h0, 1'b1, 32'h11BB33DD, 1'b0};
    v[4]  = '{wrq(4'hF, 3, 32'h0011ffff), IDLE, 1'b0, 32'h0, 1'b0, 32'h11BB33DD, 1'b0};
    v[5]  = '{wrq(4'hF, 3, 32'h0011abcd), rdq(3), 1'b0, 32'h0, 1'b1, 32'h0011ffff, 1'b0};
    v[6]  = '{IDLE, rdq(3), 1'b0, 32'h0, 1'b1, 32'h0011abcd, 1'b0};
    v[7]  = '{wrq(4'h3, 1, 32'h000000ff), wrq(4'hE, 1, 32'hffff0000), 1'b0, 32'h0, 1'b0, 32'h0011abcd, 1'b1};
    v[8]  = '{IDLE, IDLE, 1'b0, 32'h0, 1'b0, 32'h0011abcd, 1'b0};
    v[9]  = '{rdq(1), rdq(1), 1'b1, 32'hffff00ff, 1'b1, 32'hffff00ff, 1'b0};
    v[10] = '{wrq(4'h0, 1, 32'h12345678), wrq(4'h1, 1, 32'h000000AA), 1'b0, 32'hffff00ff, 1'b0, 32'hffff00ff, 1'b0};
    v[11] = '{rdq(1), IDLE, 1'b1, 32'hffff00aa, 1'b0, 32'hffff00ff, 1'b0};
    v[12] = '{wrq(4'hF, 6, 32'hCAFEF00D), wrq(4'hF, 7, 32'h01020304), 1'b0, 32'hffff00aa, 1'b0, 32'hffff00ff, 1'b0};
    v[13] = '{rdq(7), rdq(6), 1'b1, 32'h01020304, 1'b1, 32'hCAFEF00D, 1'b0};
    drive(IDLE, IDLE);
    reset_init(1'b1);
    for (int k = 0; k < 14; k++) begin
      step(v[k].a, v[k].b, 1'b0);
      check($sformatf("vec%0d_a_vld", k), 32'(a_if.vld), 32'(v[k].avld));
      check($sformatf("vec%0d_a_dout", k), a_if.dout, v[k].adout);
      check($sformatf("vec%0d_b_vld", k), 32'(b_if.vld), 32'(v[k].bvld));
      check($sformatf("vec%0d_b_dout", k), b_if.dout, v[k].bdout);
      check($sformatf("vec%0d_collision", k), 32'(collision), 32'(v[k].col));
    end
    repeat (400) step(rnd(), rnd(), 1'b1);
    step(wrq(4'hF, 4, 32'h00110000), IDLE, 1'b1);
    step(rdq(4), IDLE, 1'b1);
    drive(rdq(4), IDLE);
    #2;
    reset_init(1'b0);
    step(rdq(4), IDLE, 1'b1);
    check("reinit_addr4", a_if.dout, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dp_sram_be.md
Name: dp_sram_be

Overview:
- Parametrised true dual-port synchronous SRAM; successor to the single-port-interface 32x8 dual-port SRAM.
- Two independent read/write ports (A, B) share one clock.
- Each port has per-byte write enables and a 1-cycle registered read with a valid strobe.
- Self-clears its contents after reset. Used as a scratch/buffer memory between two datapath clients.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 3, address width in bits.
- DEPTH, 1<<ADDR_W, number of words (derived; do not override).
- BE_W, DATA_W/8, byte-enable width (derived).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- init_done  out  1  high once the post-reset clear has completed.
- a_en  in  1  port A request.
- a_wr  in  1  port A: 1 = write, 0 = read.
- a_be  in  BE_W  port A byte enables (write only).
- a_addr  in  ADDR_W  port A address.
- a_din  in  DATA_W  port A write data.
- a_dout  out  DATA_W  port A read data.
- a_vld  out  1  port A read data valid.
- b_en, b_wr, b_be, b_addr, b_din, b_dout, b_vld: same as port A, for port B.
- collision  out  1  write-write overlap pulse.

Behaviour:
- Reset (rst_n low, asynchronous):
  - init_done=0, a_dout=b_dout=0, a_vld=b_vld=0, collision=0.
  - FSM to CLEAR, clear counter = 0.
- FSM states:
  - CLEAR: writes 0 to address clr_cnt each cycle; clr_cnt increments.
  - CLEAR -> READY: after address DEPTH-1 is written. init_done rises on the edge that writes the last address, i.e. DEPTH cycles after rst_n deasserts.
  - READY: held until the next reset.
- In CLEAR, all port requests are ignored: no writes, vld stays 0.
- Reset asserted mid-operation: any in-flight read is discarded. Memory is re-cleared; contents are never preserved across reset.
- Read (en=1, wr=0, READY):
  - dout registered at the next edge; vld=1 for exactly that one cycle.
  - dout holds its last read value while vld=0.
- Write (en=1, wr=1, READY):
  - At the edge, bytes i with be[i]=1 take din[8i+7:8i]; other bytes are unchanged.
  - be=0 makes the write a no-op.
  - A write never asserts vld, and dout does not change.
- Same-address read and write on opposite ports, same cycle: the read returns the OLD word (read-first). The write lands normally.
- Write-write to the same address, same cycle:
  - Non-overlapping bytes merge.
  - Overlapping bytes take port A data (A has priority).
  - collision=1 for one cycle after the edge when (a_be & b_be) != 0; otherwise collision=0.
- Read-read to the same address: both ports return the same word; no collision.
- Addresses always lie in range, since DEPTH = 2^ADDR_W; there is no wrap logic.
- No X propagation: all outputs are defined from reset onward.

Optional Feature:
- Macro DP_SRAM_PARITY_EN.
- Defined:
  - Each byte stores an even-parity bit, computed on write; CLEAR writes parity 0.
  - Extra outputs a_perr and b_perr (1 bit each), registered alongside vld.
  - perr=1 when any read byte's stored parity mismatches its data. Reset value 0.
  - Array width becomes DATA_W+BE_W.
- Undefined: no parity storage, no perr ports; array width is DATA_W.

Decomposition:
- Package dp_sram_pkg holds:
  - FSM state typedef {CLEAR, READY}.
  - Port-priority constant PRIO_A=1.
  - Function byte_merge(old, din, be), which returns the merged word.
- Sub-module dp_sram_port: per-port read register, vld and perr generation; instantiated twice.
- The storage array, clear FSM and collision arbitration stay in the top level.

Test Plan:
- Reset clear: write 0xDEADBEEF to addr 5 before reset. Pulse rst_n, wait for init_done, read addr 5 on A.
  -> init_done high 8 cycles after release; a_dout=0x00000000, a_vld=1 for one cycle.
- Byte enables: A writes 0x11223344 be=4'b1111 to addr 2, then 0xAABBCCDD be=4'b0101 to addr 2. B reads addr 2 -> b_dout=0x11BB33DD.
- Read-first: addr 3 holds 0x0011ffff. Same cycle, A writes 0x0011abcd to addr 3 and B reads addr 3.
  -> b_dout=0x0011ffff. Next B read of addr 3 -> 0x0011abcd.
- Write collision: addr 1 cleared. Same cycle, A writes 0x000000ff be=4'b0011 and B writes 0xffff0000 be=4'b1110.
  -> collision=1 one cycle later; read addr 1 -> 0xffff00ff.
- Requests during clear: a_en=1, a_wr=1, 0x12345678 to addr 0 while init_done=0.
  -> no vld; after init_done, read addr 0 -> 0x00000000.
- Mid-read reset: A reads addr 4 (holding 0x00110000) and rst_n drops before the edge.
  -> a_vld=0, a_dout=0; after re-init, addr 4 reads 0.
